// File: rtl/ofdm_symbol_scheduler_if.sv
// Source-to-mapper byte handshake around the OFDM symbol scheduler.
// master is the scheduler side; slave is the source/mapper side.
interface ofdm_symbol_scheduler_if;
  logic [7:0] src_data;
  logic       src_valid;
  logic       src_ready;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ready;
  logic       m_last;
  logic       m_sof;

  modport master (
    input  src_data, src_valid, m_ready,
    output src_ready, m_data, m_valid, m_last, m_sof
  );

  modport slave (
    output src_data, src_valid, m_ready,
    input  src_ready, m_data, m_valid, m_last, m_sof
  );
endinterface

// File: rtl/ofdm_symbol_scheduler.sv
// Gates the source byte stream into whole OFDM symbols with a guard gap between them.
// Zero-latency pass-through in LOAD; the source is stalled (src_ready=0) in IDLE and GUARD.
module ofdm_symbol_scheduler #(
  parameter int BYTES_PER_SYM = 16,
  parameter int GUARD_CYCLES  = 48,
  parameter int SYM_CNT_W     = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic                 start,
  input  logic                 abort,
  input  logic [SYM_CNT_W-1:0] n_sym,
  ofdm_symbol_scheduler_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [SYM_CNT_W-1:0] sym_idx
);

  localparam int BW = (BYTES_PER_SYM > 1) ? $clog2(BYTES_PER_SYM) : 1;
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [BW-1:0]        LAST_BYTE  = BW'(BYTES_PER_SYM - 1);
  localparam logic [GW-1:0]        LAST_GUARD = GW'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [BW-1:0]        BYTE_ONE   = BW'(1);
  localparam logic [GW-1:0]        GUARD_ONE  = GW'(1);
  localparam logic [SYM_CNT_W-1:0] SYM_ONE    = SYM_CNT_W'(1);
  localparam logic                 HAS_GUARD  = (GUARD_CYCLES > 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_GUARD} state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BW-1:0]        r_byte_cnt;
  logic [GW-1:0]        r_guard_cnt;
  logic [SYM_CNT_W-1:0] r_sym_idx;
  logic [SYM_CNT_W-1:0] r_n_sym;
  logic                 r_done;

  logic w_xfer;
  logic w_last;
  logic w_sym_end;
  logic w_frame_end;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_xfer        = 1'b0;
    w_last        = 1'b0;
    w_sym_end     = 1'b0;
    w_frame_end   = 1'b0;
    bus.m_data    = bus.src_data;
    bus.m_valid   = 1'b0;
    bus.src_ready = 1'b0;
    bus.m_last    = 1'b0;
    bus.m_sof     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && (n_sym != '0)) w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_last        = (r_byte_cnt == LAST_BYTE);
        bus.m_valid   = bus.src_valid;
        bus.src_ready = bus.m_ready;
        bus.m_last    = w_last;
        bus.m_sof     = (r_byte_cnt == '0) && (r_sym_idx == '0);
        w_xfer        = bus.src_valid & bus.m_ready;
        w_sym_end     = w_xfer & w_last;
        w_frame_end   = w_sym_end & (r_sym_idx == r_n_sym - SYM_ONE);
        if (w_frame_end)                 w_state_nxt = S_IDLE;
        else if (w_sym_end && HAS_GUARD) w_state_nxt = S_GUARD;
      end
      S_GUARD: begin
        if (r_guard_cnt == LAST_GUARD) w_state_nxt = S_LOAD;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // Abort wins over start and over a transfer completing this cycle.
    if (abort) w_state_nxt = S_IDLE;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_byte_cnt  <= '0;
      r_guard_cnt <= '0;
      r_sym_idx   <= '0;
      r_n_sym     <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_byte_cnt  <= '0;
        r_guard_cnt <= '0;
        r_sym_idx   <= '0;
      end else begin
        if (r_state == S_IDLE && start) begin
          r_n_sym <= n_sym;
          if (n_sym == '0) r_done <= 1'b1;
        end
        if (w_xfer) r_byte_cnt <= w_last ? '0 : r_byte_cnt + BYTE_ONE;
        if (w_sym_end) r_sym_idx <= w_frame_end ? '0 : r_sym_idx + SYM_ONE;
        if (w_frame_end) r_done <= 1'b1;
        if (r_state == S_GUARD)
          r_guard_cnt <= (r_guard_cnt == LAST_GUARD) ? '0 : r_guard_cnt + GUARD_ONE;
      end
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign sym_idx = r_sym_idx;

endmodule

// File: tb/tb_ofdm_symbol_scheduler.sv
// Directed bench for ofdm_symbol_scheduler: default build plus a zero-guard build.
module tb_ofdm_symbol_scheduler;
  logic       aclk = 1'b0;
  logic       aresetn;
  logic       start, abort;
  logic [7:0] n_sym;
  logic       busy, done;
  logic [7:0] sym_idx;
  logic       start0, abort0;
  logic [7:0] n_sym0;
  logic       busy0, done0;
  logic [7:0] sym_idx0;

  int n_cmp = 0;
  int n_err = 0;

  ofdm_symbol_scheduler_if bus ();
  ofdm_symbol_scheduler_if bus0 ();

  ofdm_symbol_scheduler dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .abort(abort), .n_sym(n_sym),
    .bus(bus.master), .busy(busy), .done(done), .sym_idx(sym_idx)
  );

  ofdm_symbol_scheduler #(.GUARD_CYCLES(0)) dut_g0 (
    .aclk(aclk), .aresetn(aresetn), .start(start0), .abort(abort0), .n_sym(n_sym0),
    .bus(bus0.master), .busy(busy0), .done(done0), .sym_idx(sym_idx0)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_cmp++;
    assert (observed === expected) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    logic [7:0] d;
    int k;
    aresetn = 1'b0; start = 1'b0; abort = 1'b0; n_sym = 8'd0;
    start0 = 1'b0; abort0 = 1'b0; n_sym0 = 8'd0;
    bus.src_data = 8'h00; bus.src_valid = 1'b0; bus.m_ready = 1'b0;
    bus0.src_data = 8'h00; bus0.src_valid = 1'b0; bus0.m_ready = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_src_ready", bus.src_ready, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_m_sof", bus.m_sof, 0);
    check("rst_sym_idx", sym_idx, 0);
    #12 aresetn = 1'b1;
    step();

    // Two symbols of 0xAA with continuous handshake
    start = 1'b1; n_sym = 8'd2; bus.src_valid = 1'b1; bus.m_ready = 1'b1; bus.src_data = 8'hAA;
    #1;
    check("t1_busy_pre", busy, 0);
    step();
    start = 1'b0; n_sym = 8'd7;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("t1_s0_valid", bus.m_valid, 1);
      check("t1_s0_data", bus.m_data, 8'hAA);
      check("t1_s0_sof", bus.m_sof, (i == 0));
      check("t1_s0_last", bus.m_last, (i == 15));
      check("t1_s0_busy", busy, 1);
      step();
    end
    for (int g = 0; g < 48; g++) begin
      check("t1_guard_rdy", bus.src_ready, 0);
      check("t1_guard_valid", bus.m_valid, 0);
      check("t1_guard_busy", busy, 1);
      step();
    end
    for (int i = 0; i < 16; i++) begin
      check("t1_s1_valid", bus.m_valid, 1);
      check("t1_s1_sof", bus.m_sof, 0);
      check("t1_s1_last", bus.m_last, (i == 15));
      check("t1_s1_idx", sym_idx, 1);
      check("t1_s1_done", done, 0);
      step();
    end
    check("t1_busy_end", busy, 0);
    check("t1_done", done, 1);
    check("t1_idx_end", sym_idx, 0);
    step();
    check("t1_done_clr", done, 0);

    // Toggling m_ready, incrementing source bytes
    d = 8'h00; k = 0;
    start = 1'b1; n_sym = 8'd1; bus.src_data = d;
    step();
    start = 1'b0;
    #1;
    for (int c = 0; c < 64 && busy; c++) begin
      bus.m_ready = (c % 2 == 0);
      bus.src_data = d;
      #1;
      check("t2_rdy_mirror", bus.src_ready, bus.m_ready);
      if (bus.m_ready) begin
        check("t2_data", bus.m_data, k);
        check("t2_last", bus.m_last, (k == 15));
        k++;
        d = d + 8'd1;
      end
      step();
    end
    check("t2_count", k, 16);
    check("t2_done", done, 1);
    bus.m_ready = 1'b1;

    // Zero-symbol frame
    step();
    start = 1'b1; n_sym = 8'd0;
    step();
    start = 1'b0;
    #1;
    check("t3_busy", busy, 0);
    check("t3_done", done, 1);
    check("t3_rdy", bus.src_ready, 0);
    step();
    check("t3_done_clr", done, 0);

    // Abort on byte 7 of symbol 1
    bus.src_data = 8'h55;
    start = 1'b1; n_sym = 8'd3;
    step();
    start = 1'b0;
    repeat (16 + 48 + 7) step();
    check("t4_idx_pre", sym_idx, 1);
    check("t4_valid_pre", bus.m_valid, 1);
    check("t4_last_pre", bus.m_last, 0);
    abort = 1'b1;
    step();
    abort = 1'b0;
    #1;
    check("t4_busy", busy, 0);
    check("t4_idx", sym_idx, 0);
    check("t4_done", done, 0);
    step();
    check("t4_done2", done, 0);
    start = 1'b1; n_sym = 8'd1;
    step();
    start = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("t4_sof", bus.m_sof, (i == 0));
      check("t4_last", bus.m_last, (i == 15));
      step();
    end
    check("t4_frame_done", done, 1);

    // Asynchronous reset in the middle of GUARD
    step();
    start = 1'b1; n_sym = 8'd2;
    step();
    start = 1'b0;
    repeat (16 + 10) step();
    check("t5_busy_guard", busy, 1);
    check("t5_idx_guard", sym_idx, 1);
    #2 aresetn = 1'b0;
    #1;
    check("t5_rst_busy", busy, 0);
    check("t5_rst_idx", sym_idx, 0);
    check("t5_rst_rdy", bus.src_ready, 0);
    check("t5_rst_valid", bus.m_valid, 0);
    check("t5_rst_done", done, 0);
    @(negedge aclk);
    aresetn = 1'b1;
    step();
    start = 1'b1; n_sym = 8'd1;
    step();
    start = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check("t5_sof", bus.m_sof, (i == 0));
      check("t5_last", bus.m_last, (i == 15));
      check("t5_valid", bus.m_valid, 1);
      step();
    end
    check("t5_done", done, 1);

    // Zero-guard build: 64 back-to-back transfers
    bus0.src_valid = 1'b1; bus0.m_ready = 1'b1;
    start0 = 1'b1; n_sym0 = 8'd4;
    step();
    start0 = 1'b0;
    #1;
    for (int i = 0; i < 64; i++) begin
      bus0.src_data = 8'(i);
      #1;
      check("t6_valid", bus0.m_valid, 1);
      check("t6_data", bus0.m_data, i);
      check("t6_last", bus0.m_last, ((i % 16) == 15));
      check("t6_sof", bus0.m_sof, (i == 0));
      check("t6_idx", sym_idx0, i / 16);
      step();
    end
    check("t6_busy", busy0, 0);
    check("t6_done", done0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ofdm_symbol_scheduler.md
Name: ofdm_symbol_scheduler

Overview:
- Sequences the byte stream from the LFSR/pattern source into whole OFDM symbols for the 16QAM mapper. Default build is N=32 subcarriers, 4 bits each, so 16 bytes per symbol.
- After each symbol, holds the source off for a fixed guard window so the IFFT and CP-16 insertion can drain.
- Counts symbols per frame and flags start-of-frame, end-of-symbol and frame done.
- Sits between the source generator and the mapper, and owns the source's ready.

Parameters:
- BYTES_PER_SYM, 16, bytes forwarded per OFDM symbol (32 subcarriers x 4 bits / 8).
- GUARD_CYCLES, 48, idle cycles between symbols (N + CP = 32 + 16); 0 allowed.
- SYM_CNT_W, 8, width of the symbol-count config and status.

Ports:
- aclk  in  1  sole clock, rising edge.
- aresetn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; starts a frame; honoured only in IDLE.
- abort  in  1  synchronous abort; returns to IDLE on the next edge.
- n_sym  in  SYM_CNT_W  symbols per frame; latched when start is accepted.
- src_data  in  8  byte from the source generator.
- src_valid  in  1  source byte valid.
- src_ready  out  1  to source: byte accepted this cycle.
- m_data  out  8  byte to the mapper.
- m_valid  out  1  m_data valid.
- m_ready  in  1  mapper accepts.
- m_last  out  1  last byte of the current symbol.
- m_sof  out  1  first byte of the frame.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when the frame completes.
- sym_idx  out  SYM_CNT_W  index of the current symbol (0-based).

Behaviour:
- Reset (aresetn=0, asynchronous):
  - State goes to IDLE.
  - Byte, guard and symbol counters, and latched n_sym, clear to 0.
  - done=0 and busy=0.
  - Combinational outputs are therefore src_ready=0, m_valid=0, m_last=0, m_sof=0.
  - Release is synchronous to aclk.
- States and transitions:
  - IDLE -> LOAD on start when latched n_sym != 0.
  - IDLE -> IDLE on start with n_sym == 0, and done pulses on the next cycle.
  - LOAD -> GUARD on the transfer of byte BYTES_PER_SYM-1 when more symbols remain and GUARD_CYCLES > 0.
  - LOAD -> LOAD (next symbol) on that same transfer when GUARD_CYCLES == 0.
  - LOAD -> IDLE on the transfer of the last byte of the last symbol; done pulses on the cycle after that transfer.
  - GUARD -> LOAD after exactly GUARD_CYCLES cycles spent in GUARD.
- Datapath in LOAD (combinational, zero latency):
  - m_data = src_data.
  - m_valid = src_valid.
  - src_ready = m_ready.
  - A transfer occurs when src_valid & m_ready.
- Datapath outside LOAD: m_valid=0 and src_ready=0. The source is fully stalled and holds its byte.
- Byte counter:
  - Increments per transfer and wraps to 0 after BYTES_PER_SYM-1.
  - m_last = LOAD & (byte_cnt == BYTES_PER_SYM-1).
  - m_sof = LOAD & (byte_cnt == 0) & (sym_idx == 0).
  - Both are qualified only by state; they are meaningful when m_valid=1.
- sym_idx:
  - Increments on each symbol-final transfer.
  - Returns to 0 when the frame completes.
- Symbols per frame is n_sym as latched. Changes to n_sym mid-frame are ignored.
- Boundary conditions:
  - Stalls (m_ready=0 or src_valid=0) freeze all counters; no byte is dropped or duplicated.
  - start while busy is ignored.
  - abort has priority over start and over a simultaneous transfer. The transfer completes on the bus, but counters clear, state goes to IDLE, and done is not pulsed.
  - Reset mid-frame discards the frame silently.

Test Plan:
- Default parameters, n_sym=2, src_valid and m_ready held 1, source sends 0xAA:
  - 16 bytes of 0xAA with m_sof on byte 0 and m_last on byte 15.
  - Then 48 cycles with src_ready=0.
  - Then 16 more bytes with m_last on byte 15 and m_sof=0.
  - done pulses 1 cycle after the final transfer; busy is high over exactly 80 cycles.
- m_ready toggled 1/0 every cycle, n_sym=1, incrementing source data 0x00..0x0F:
  - m_data sequence is exactly 0x00..0x0F, with no repeats or gaps.
  - src_ready mirrors m_ready.
- start with n_sym=0 -> no transfers, busy stays 0, done pulses next cycle.
- abort asserted on byte 7 of symbol 1 with n_sym=3:
  - Next cycle: IDLE, busy=0, sym_idx=0, no done pulse.
  - A following start with n_sym=1 begins again with m_sof.
- aresetn pulled low asynchronously mid-GUARD:
  - Outputs go to reset values immediately without a clock edge.
  - After release, a start gives a normal frame.
- GUARD_CYCLES=0 build, n_sym=4, continuous handshake:
  - 64 back-to-back transfers.
  - m_last on transfers 15, 31, 47 and 63.
  - sym_idx steps 0 to 3.
